// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default
// bus widths and the packed command bundle latched at accept time.
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int APB_NB = APB_DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Latched request; wdata/strb are already zeroed for reads so
  // the bus drivers can use the fields directly.
  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_NB-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer
// (IDLE/SETUP/ACCESS), honours PREADY wait states and aborts on timeout.
// Ports: PCLK/PRESET (async, active-high); cmd_* request handshake;
// rsp_* one-cycle completion pulse with read data and timeout flag;
// PSELx/PENABLE/PADDR/PWRITE/PSTRB/PWDATA registered bus outputs;
// PRDATA/PREADY from the slave.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DW,
  parameter int ADDR_WIDTH     = APB_AW,
  parameter int NBYTES         = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [NBYTES-1:0]     cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [NBYTES-1:0]     PSTRB,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort fires on the wait cycle that brings the count to the limit.
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic psel_q, psel_d;
  logic pen_q, pen_d;
  logic rv_q, rv_d;
  logic rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    psel_d  = psel_q;
    pen_d   = pen_q;
    rv_d    = 1'b0;
    rerr_d  = rerr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = APB_AW'(cmd_addr);
          cmd_d.wdata = cmd_write ? APB_DW'(cmd_wdata) : '0;
          cmd_d.strb  = cmd_write ? APB_NB'(cmd_strb) : '0;
          cnt_d       = '0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rerr_d  = 1'b0;
          rdata_d = cmd_q.write ? '0 : PRDATA;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign PSELx     = psel_q;
  assign PENABLE   = pen_q;
  assign PADDR     = ADDR_WIDTH'(cmd_q.addr);
  assign PWRITE    = cmd_q.write;
  assign PSTRB     = NBYTES'(cmd_q.strb);
  assign PWDATA    = DATA_WIDTH'(cmd_q.wdata);

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of transfers against a
// small APB slave model, plus hand sequences for multi-cycle cases.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSELx, PWRITE, PENABLE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSELx(PSELx), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [logic [31:0]];
  int  waits_cfg = 0;
  bit  ready_tied = 0;
  int  wcnt = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(negedge PCLK) begin
    if (PRESET) begin
      wcnt = 0; PREADY = 1'b0; PRDATA = 32'h0;
    end else if (ready_tied) begin
      PREADY = 1'b1; PRDATA = rd(PADDR);
    end else if (PSELx && PENABLE) begin
      if (wcnt >= waits_cfg) begin
        PREADY = 1'b1; PRDATA = rd(PADDR);
      end else begin
        PREADY = 1'b0; PRDATA = 32'hBAD0_0000;
      end
      wcnt++;
    end else begin
      wcnt = 0; PREADY = 1'b0; PRDATA = 32'hBAD0_0000;
    end
  end

  always @(posedge PCLK) begin
    if (!PRESET && PSELx && PENABLE && PREADY && PWRITE) begin
      logic [31:0] w;
      w = rd(PADDR);
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) w[b*8 +: 8] = PWDATA[b*8 +: 8];
      mem[PADDR] = w;
    end
  end

  logic [68:0] snap;
  logic prev_setup = 1'b0;
  logic prev_pen = 1'b0;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      chk("pen_without_sel", PENABLE & ~PSELx, 0);
      if (PENABLE && !prev_pen) chk("pen_after_setup", prev_setup, 1);
      if (PSELx && !PENABLE) snap = {PADDR, PWRITE, PSTRB, PWDATA};
      if (PSELx && PENABLE)
        chk("bus_hold", {PADDR, PWRITE, PSTRB, PWDATA}, snap);
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=1 expected=0 @%0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
        end
      end
      prev_setup = PSELx & ~PENABLE;
      prev_pen = PENABLE;
    end else begin
      prev_setup = 1'b0;
      prev_pen = 1'b0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          tied;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[8];

  task automatic drive_cmd(input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    int n;
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    while (!cmd_ready && n < 40) begin @(negedge PCLK); n++; end
    chk("accept_wait", n < 40, 1);
    @(posedge PCLK);
  endtask

  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 40) begin @(negedge PCLK); lat++; end
  endtask

  initial begin : stim
    int lat;
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    mem[32'h20] = 32'h1234_5678;

    vecs[0] = '{1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0, 0, 3};
    vecs[1] = '{0, 32'h20, 32'hFFFF_FFFF, 4'hF, 2, 0, 32'h1234_5678, 0, 5};
    vecs[2] = '{0, 32'h10, 32'h5555_5555, 4'hA, 0, 0, 32'hDEAD_BEEF, 0, 3};
    vecs[3] = '{1, 32'h30, 32'hAABB_CCDD, 4'h5, 1, 0, 32'h0, 0, 4};
    vecs[4] = '{0, 32'h30, 32'h0, 4'h0, 3, 0, 32'h00BB_00DD, 0, 6};
    vecs[5] = '{0, 32'h50, 32'h0, 4'h0, 100, 0, 32'h0, 1, 6};
    vecs[6] = '{1, 32'h54, 32'h1111_2222, 4'hF, 100, 0, 32'h0, 1, 6};
    vecs[7] = '{0, 32'h30, 32'h0, 4'h0, 4, 0, 32'h0, 1, 6};

    #12;
    chk("reset_outs",
        {PSELx, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
         rsp_valid, rsp_rdata, rsp_err}, 0);
    @(negedge PCLK); PRESET = 1'b0;
    @(negedge PCLK);
    chk("reset_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      waits_cfg = vecs[i].waits; ready_tied = vecs[i].tied;
      drive_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      sb_q.push_back('{vecs[i].exp_rdata, vecs[i].exp_err});
      #1;
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
      @(negedge PCLK);
      chk("setup_ctl", {PSELx, PENABLE, cmd_ready}, 3'b100);
      chk("setup_addr", {PADDR, PWRITE}, {vecs[i].addr, vecs[i].wr});
      chk("setup_data", {PSTRB, PWDATA},
          vecs[i].wr ? {vecs[i].strb, vecs[i].wdata} : 36'h0);
      wait_rsp(1, lat);
      chk("latency", lat, vecs[i].exp_lat);
      chk("end_idle", {PSELx, PENABLE, cmd_ready}, 3'b001);
    end
    ready_tied = 0;

    // back-to-back: write then read of 0x04 with cmd_valid held
    @(negedge PCLK);
    waits_cfg = 0;
    drive_cmd(1, 32'h04, 32'hCAFE_F00D, 4'hF);
    sb_q.push_back('{32'h0, 1'b0});
    #1;
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    wait_rsp(0, lat);
    chk("b2b_lat1", lat, 3);
    chk("b2b_gap", {PSELx, cmd_ready}, 2'b01);
    @(posedge PCLK);
    sb_q.push_back('{32'hCAFE_F00D, 1'b0});
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("b2b_setup", {PSELx, PENABLE, PADDR, PWRITE},
        {1'b1, 1'b0, 32'h04, 1'b0});
    wait_rsp(1, lat);
    chk("b2b_lat2", lat, 3);

    // busy rejection: request changes while ACCESS stretches
    @(negedge PCLK);
    waits_cfg = 3;
    drive_cmd(1, 32'h60, 32'h0F0F_0F0F, 4'hF);
    sb_q.push_back('{32'h0, 1'b0});
    #1;
    lat = 0;
    while (lat < 40) begin
      @(negedge PCLK); lat++;
      if (rsp_valid) break;
      cmd_addr = 32'h99 + lat;
      chk("busy_ready", cmd_ready, 0);
      chk("busy_paddr", PADDR, 32'h60);
    end
    cmd_valid = 1'b0;
    chk("busy_lat", lat, 6);
    @(negedge PCLK);
    chk("busy_no_accept", PSELx, 0);

    // reset during a wait state
    @(negedge PCLK);
    waits_cfg = 100;
    drive_cmd(0, 32'h20, 32'h0, 4'h0);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("pre_rst_access", {PSELx, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_drop", {PSELx, PENABLE, rsp_valid}, 3'b000);
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      chk("rst_idle", {cmd_ready, PSELx, rsp_valid}, 3'b100);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
